// File: rtl/sap_core_param_if.sv
// Memory bus between sap_core_param and its synchronous single-port program/data memory.
interface sap_core_param_if #(
    parameter int DW = 8,
    parameter int AW = 4
);
    logic [AW-1:0] mem_addr;
    logic          mem_rd_en;
    logic [DW-1:0] mem_rdata;
    logic          mem_wr_en;
    logic [DW-1:0] mem_wdata;

    modport master (output mem_addr, mem_rd_en, mem_wr_en, mem_wdata, input mem_rdata);
    modport slave  (input mem_addr, mem_rd_en, mem_wr_en, mem_wdata, output mem_rdata);
endinterface

// File: rtl/sap_core_param.sv
// Parametrised accumulator CPU core: FETCH/LATCH/DECODE/EXEC sequencer, PC, IR,
// A/B registers, flags, output port and optional MUL/DIV with registered memory strobes.
module sap_core_param #(
    parameter int DW         = 8,
    parameter int AW         = 4,
    parameter int HAS_MULDIV = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    sap_core_param_if.master     mem,
    output logic                 out_valid,
    output logic [DW-1:0]        out_data,
    output logic [AW-1:0]        pc,
    output logic [DW-1:0]        a_reg,
    output logic [DW-1:0]        b_reg,
    output logic                 flag_z,
    output logic                 flag_c,
    output logic                 halted
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LATCH, S_DECODE, S_EXEC, S_HALT
    } state_e;

    localparam logic [3:0] OP_SUB = 4'b0001, OP_ADD = 4'b0010, OP_STA = 4'b0011;
    localparam logic [3:0] OP_LDB = 4'b0100, OP_LDA = 4'b1000, OP_JMP = 4'b1001;
    localparam logic [3:0] OP_DIV = 4'b1010, OP_JZ  = 4'b1011, OP_MUL = 4'b1100;
    localparam logic [3:0] OP_OUT = 4'b1110, OP_HLT = 4'b1111;

    function automatic logic needs_operand(input logic [3:0] op);
        case (op)
            OP_LDA, OP_LDB, OP_ADD, OP_SUB: needs_operand = 1'b1;
            OP_MUL, OP_DIV:                 needs_operand = (HAS_MULDIV != 0);
            default:                        needs_operand = 1'b0;
        endcase
    endfunction

    state_e          state_q, state_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic [3:0]      ir_op_q, ir_op_d;
    logic [AW-1:0]   ir_m_q, ir_m_d;
    logic [DW-1:0]   a_q, a_d, b_q, b_d;
    logic            z_q, z_d, c_q, c_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d;
    logic            halted_q, halted_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            rd_q, rd_d, wr_q, wr_d;
    logic [DW-1:0]   wdata_q, wdata_d;

    logic [3:0]      rd_op;
    logic [AW-1:0]   rd_m;
    logic [DW:0]     sum, diff;
    logic [2*DW-1:0] prod;
    logic [DW-1:0]   quo;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_op_d     = ir_op_q;
        ir_m_d      = ir_m_q;
        a_d         = a_q;
        b_d         = b_q;
        z_d         = z_q;
        c_d         = c_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        addr_d      = addr_q;
        rd_d        = 1'b0;
        wr_d        = 1'b0;
        wdata_d     = wdata_q;
        rd_op       = mem.mem_rdata[DW-1 -: 4];
        rd_m        = mem.mem_rdata[AW-1:0];
        sum         = {1'b0, a_q} + {1'b0, mem.mem_rdata};
        diff        = {1'b0, a_q} - {1'b0, mem.mem_rdata};
        prod        = {{DW{1'b0}}, a_q} * {{DW{1'b0}}, mem.mem_rdata};
        quo         = (mem.mem_rdata == '0) ? '1 : a_q / mem.mem_rdata;

        case (state_q)
            S_IDLE:  if (run) state_d = S_FETCH;
            S_FETCH: state_d = S_LATCH;
            S_LATCH: begin
                // Strobes seen in DECODE are registered here from the incoming instruction word.
                ir_op_d = rd_op;
                ir_m_d  = rd_m;
                pc_d    = pc_q + AW'(1);
                state_d = S_DECODE;
                if (needs_operand(rd_op)) begin
                    rd_d   = 1'b1;
                    addr_d = rd_m;
                end else if (rd_op == OP_STA) begin
                    wr_d    = 1'b1;
                    addr_d  = rd_m;
                    wdata_d = a_q;
                end else if (rd_op == OP_OUT) begin
                    out_valid_d = 1'b1;
                    out_data_d  = a_q;
                end
            end
            S_DECODE: begin
                if (needs_operand(ir_op_q)) begin
                    state_d = S_EXEC;
                end else if (ir_op_q == OP_HLT) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_FETCH;
                    if (ir_op_q == OP_JMP || (ir_op_q == OP_JZ && z_q)) pc_d = ir_m_q;
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (ir_op_q)
                    OP_LDA: begin a_d = mem.mem_rdata; z_d = (mem.mem_rdata == '0); c_d = 1'b0; end
                    OP_LDB: begin b_d = mem.mem_rdata; z_d = (mem.mem_rdata == '0); c_d = 1'b0; end
                    OP_ADD: begin b_d = sum[DW-1:0];  z_d = (sum[DW-1:0] == '0);  c_d = sum[DW]; end
                    OP_SUB: begin b_d = diff[DW-1:0]; z_d = (diff[DW-1:0] == '0); c_d = diff[DW]; end
                    OP_MUL: begin
                        b_d = prod[DW-1:0];
                        z_d = (prod[DW-1:0] == '0);
                        c_d = |prod[2*DW-1:DW];
                    end
                    OP_DIV: begin b_d = quo; z_d = (quo == '0); c_d = (mem.mem_rdata == '0); end
                    default: ;
                endcase
            end
            S_HALT:  if (run) state_d = S_FETCH;
            default: state_d = S_IDLE;
        endcase

        // Every entry into FETCH issues the instruction read at the (possibly redirected) pc.
        if (state_d == S_FETCH) begin
            rd_d   = 1'b1;
            addr_d = pc_d;
        end
        halted_d = (state_d == S_HALT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            ir_op_q     <= '0;
            ir_m_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            z_q         <= 1'b0;
            c_q         <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            halted_q    <= 1'b0;
            addr_q      <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_op_q     <= ir_op_d;
            ir_m_q      <= ir_m_d;
            a_q         <= a_d;
            b_q         <= b_d;
            z_q         <= z_d;
            c_q         <= c_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            halted_q    <= halted_d;
            addr_q      <= addr_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            wdata_q     <= wdata_d;
        end
    end

    assign mem.mem_addr  = addr_q;
    assign mem.mem_rd_en = rd_q;
    assign mem.mem_wr_en = wr_q;
    assign mem.mem_wdata = wdata_q;
    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign pc            = pc_q;
    assign a_reg         = a_q;
    assign b_reg         = b_q;
    assign flag_z        = z_q;
    assign flag_c        = c_q;
    assign halted        = halted_q;
endmodule

// File: tb/tb_sap_core_param.sv
// Directed self-checking bench for sap_core_param: one core with MUL/DIV, one without,
// each on its own synchronous memory model loaded from a shared program image.
module tb_sap_core_param;
    localparam int DW = 8;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic reset, run, run0, load, mon_clr;
    always #5 clk = ~clk;

    sap_core_param_if #(.DW(DW), .AW(AW)) bus1 ();
    sap_core_param_if #(.DW(DW), .AW(AW)) bus0 ();

    logic          out_valid, flag_z, flag_c, halted;
    logic [DW-1:0] out_data, a_reg, b_reg;
    logic [AW-1:0] pc;
    logic          out_valid0, flag_z0, flag_c0, halted0;
    logic [DW-1:0] out_data0, a_reg0, b_reg0;
    logic [AW-1:0] pc0;

    sap_core_param #(.DW(DW), .AW(AW), .HAS_MULDIV(1)) dut (
        .clk(clk), .reset(reset), .run(run), .mem(bus1),
        .out_valid(out_valid), .out_data(out_data), .pc(pc), .a_reg(a_reg), .b_reg(b_reg),
        .flag_z(flag_z), .flag_c(flag_c), .halted(halted)
    );

    sap_core_param #(.DW(DW), .AW(AW), .HAS_MULDIV(0)) dut0 (
        .clk(clk), .reset(reset), .run(run0), .mem(bus0),
        .out_valid(out_valid0), .out_data(out_data0), .pc(pc0), .a_reg(a_reg0), .b_reg(b_reg0),
        .flag_z(flag_z0), .flag_c(flag_c0), .halted(halted0)
    );

    logic [DW-1:0] img  [16];
    logic [DW-1:0] mem1 [16];
    logic [DW-1:0] mem0 [16];

    always @(posedge clk) begin
        if (load) mem1 <= img;
        else if (bus1.mem_wr_en) mem1[bus1.mem_addr] <= bus1.mem_wdata;
        if (bus1.mem_rd_en) bus1.mem_rdata <= mem1[bus1.mem_addr];
    end

    always @(posedge clk) begin
        if (load) mem0 <= img;
        else if (bus0.mem_wr_en) mem0[bus0.mem_addr] <= bus0.mem_wdata;
        if (bus0.mem_rd_en) bus0.mem_rdata <= mem0[bus0.mem_addr];
    end

    int cyc = 0;
    int last_rd1 [16];
    int last_rd0 [16];
    int wr_cnt1, ovl1, out_cnt1;
    logic [DW-1:0] out_last1, wd_last1;
    logic [AW-1:0] wa_last1;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (mon_clr) begin
            for (int i = 0; i < 16; i++) begin
                last_rd1[i] <= -1;
                last_rd0[i] <= -1;
            end
            wr_cnt1 <= 0; ovl1 <= 0; out_cnt1 <= 0;
            out_last1 <= '0; wd_last1 <= '0; wa_last1 <= '0;
        end else begin
            if (bus1.mem_rd_en) last_rd1[bus1.mem_addr] <= cyc;
            if (bus0.mem_rd_en) last_rd0[bus0.mem_addr] <= cyc;
            if (bus1.mem_wr_en) begin
                wr_cnt1  <= wr_cnt1 + 1;
                wd_last1 <= bus1.mem_wdata;
                wa_last1 <= bus1.mem_addr;
            end
            if (bus1.mem_rd_en && bus1.mem_wr_en) ovl1 <= ovl1 + 1;
            if (out_valid) begin
                out_cnt1  <= out_cnt1 + 1;
                out_last1 <= out_data;
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic clear_img();
        foreach (img[i]) img[i] = '0;
    endtask

    task automatic prep();
        reset = 1'b1; run = 1'b0; run0 = 1'b0; load = 1'b1; mon_clr = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0; load = 1'b0; mon_clr = 1'b0;
    endtask

    task automatic start_and_wait(input bit sel0, output bit ok);
        if (sel0) run0 = 1'b1; else run = 1'b1;
        @(negedge clk);
        run = 1'b0; run0 = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if ((sel0 ? halted0 : halted) === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_basic();
        bit ok;
        clear_img();
        img[0] = 8'h83; img[1] = 8'h24; img[2] = 8'hE0; img[3] = 8'h05; img[4] = 8'h07; img[5] = 8'hF0;
        prep();
        start_and_wait(1'b0, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL basic_halt_timeout: got %0b expected 1", ok); end
        n_checks++; if (a_reg !== 8'd5) begin n_fail++; $display("FAIL basic_a: got %0d expected 5", a_reg); end
        n_checks++; if (b_reg !== 8'd12) begin n_fail++; $display("FAIL basic_b: got %0d expected 12", b_reg); end
        n_checks++; if (out_cnt1 !== 1) begin n_fail++; $display("FAIL basic_out_pulses: got %0d expected 1", out_cnt1); end
        n_checks++; if (out_last1 !== 8'd5) begin n_fail++; $display("FAIL basic_out_data: got %0d expected 5", out_last1); end
        n_checks++; if (out_data !== 8'd5) begin n_fail++; $display("FAIL basic_out_hold: got %0d expected 5", out_data); end
        n_checks++; if (pc !== 4'd6) begin n_fail++; $display("FAIL basic_pc: got %0d expected 6", pc); end
        n_checks++; if (last_rd1[1] - last_rd1[0] !== 4) begin n_fail++; $display("FAIL basic_lda_cycles: got %0d expected 4", last_rd1[1] - last_rd1[0]); end
        n_checks++; if (last_rd1[3] - last_rd1[2] !== 3) begin n_fail++; $display("FAIL basic_out_cycles: got %0d expected 3", last_rd1[3] - last_rd1[2]); end
        n_checks++; if (ovl1 !== 0) begin n_fail++; $display("FAIL basic_strobe_overlap: got %0d expected 0", ovl1); end
    endtask

    task automatic test_reset();
        prep();
        @(negedge clk);
        n_checks++; if (pc !== 4'd0) begin n_fail++; $display("FAIL reset_pc: got %0d expected 0", pc); end
        n_checks++; if ({a_reg, b_reg, out_data} !== 24'h0) begin n_fail++; $display("FAIL reset_regs: got %0h expected 0", {a_reg, b_reg, out_data}); end
        n_checks++; if ({flag_z, flag_c, halted, out_valid} !== 4'b0) begin n_fail++; $display("FAIL reset_bits: got %0b expected 0", {flag_z, flag_c, halted, out_valid}); end
        n_checks++; if ({bus1.mem_rd_en, bus1.mem_wr_en} !== 2'b0) begin n_fail++; $display("FAIL reset_strobes: got %0b expected 0", {bus1.mem_rd_en, bus1.mem_wr_en}); end
    endtask

    task automatic test_arith();
        bit ok;
        clear_img();
        img[0] = 8'h88; img[1] = 8'h29; img[2] = 8'hF0; img[8] = 8'd200; img[9] = 8'd100;
        prep(); start_and_wait(1'b0, ok);
        n_checks++; if ({ok, b_reg, flag_c, flag_z} !== {1'b1, 8'd44, 1'b1, 1'b0}) begin n_fail++; $display("FAIL add_carry: got ok=%0b b=%0d c=%0b z=%0b expected ok=1 b=44 c=1 z=0", ok, b_reg, flag_c, flag_z); end
        img[1] = 8'h19; img[8] = 8'd3; img[9] = 8'd3;
        prep(); start_and_wait(1'b0, ok);
        n_checks++; if ({ok, b_reg, flag_c, flag_z} !== {1'b1, 8'd0, 1'b0, 1'b1}) begin n_fail++; $display("FAIL sub_zero: got ok=%0b b=%0d c=%0b z=%0b expected ok=1 b=0 c=0 z=1", ok, b_reg, flag_c, flag_z); end
        img[9] = 8'd4;
        prep(); start_and_wait(1'b0, ok);
        n_checks++; if ({ok, b_reg, flag_c, flag_z} !== {1'b1, 8'd255, 1'b1, 1'b0}) begin n_fail++; $display("FAIL sub_borrow: got ok=%0b b=%0d c=%0b z=%0b expected ok=1 b=255 c=1 z=0", ok, b_reg, flag_c, flag_z); end
    endtask

    task automatic test_sta_ldb();
        bit ok;
        clear_img();
        img[0] = 8'h88; img[1] = 8'h39; img[2] = 8'h49; img[3] = 8'hF0; img[8] = 8'h5A;
        prep(); start_and_wait(1'b0, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL sta_timeout: got %0b expected 1", ok); end
        n_checks++; if (wr_cnt1 !== 1) begin n_fail++; $display("FAIL sta_wr_cycles: got %0d expected 1", wr_cnt1); end
        n_checks++; if ({wa_last1, wd_last1} !== {4'd9, 8'h5A}) begin n_fail++; $display("FAIL sta_wr_bus: got %0h expected 95a", {wa_last1, wd_last1}); end
        n_checks++; if (mem1[9] !== 8'h5A) begin n_fail++; $display("FAIL sta_mem: got %0h expected 5a", mem1[9]); end
        n_checks++; if (b_reg !== 8'h5A) begin n_fail++; $display("FAIL sta_ldb: got %0h expected 5a", b_reg); end
        n_checks++; if (ovl1 !== 0) begin n_fail++; $display("FAIL sta_strobe_overlap: got %0d expected 0", ovl1); end
    endtask

    task automatic test_jz();
        bit ok;
        clear_img();
        img[0] = 8'h88; img[1] = 8'hB4; img[2] = 8'h49; img[3] = 8'hF0; img[4] = 8'hF0; img[9] = 8'h11;
        prep(); start_and_wait(1'b0, ok);
        n_checks++; if ({ok, pc, b_reg} !== {1'b1, 4'd5, 8'h00}) begin n_fail++; $display("FAIL jz_taken: got ok=%0b pc=%0d b=%0h expected ok=1 pc=5 b=0", ok, pc, b_reg); end
        img[8] = 8'h01;
        prep(); start_and_wait(1'b0, ok);
        n_checks++; if ({ok, pc, b_reg} !== {1'b1, 4'd4, 8'h11}) begin n_fail++; $display("FAIL jz_not_taken: got ok=%0b pc=%0d b=%0h expected ok=1 pc=4 b=11", ok, pc, b_reg); end
    endtask

    task automatic test_muldiv();
        bit ok;
        clear_img();
        img[0] = 8'h88; img[1] = 8'hA9; img[2] = 8'hF0; img[8] = 8'd7; img[9] = 8'd0;
        prep(); start_and_wait(1'b0, ok);
        n_checks++; if ({ok, b_reg, flag_c, flag_z} !== {1'b1, 8'd255, 1'b1, 1'b0}) begin n_fail++; $display("FAIL div_zero: got ok=%0b b=%0d c=%0b z=%0b expected ok=1 b=255 c=1 z=0", ok, b_reg, flag_c, flag_z); end
        img[8] = 8'd200; img[9] = 8'd7;
        prep(); start_and_wait(1'b0, ok);
        n_checks++; if ({ok, b_reg, flag_c, flag_z} !== {1'b1, 8'd28, 1'b0, 1'b0}) begin n_fail++; $display("FAIL div_normal: got ok=%0b b=%0d c=%0b z=%0b expected ok=1 b=28 c=0 z=0", ok, b_reg, flag_c, flag_z); end
        img[1] = 8'hC8; img[8] = 8'd16;
        prep(); start_and_wait(1'b0, ok);
        n_checks++; if ({ok, b_reg, flag_c, flag_z} !== {1'b1, 8'd0, 1'b1, 1'b1}) begin n_fail++; $display("FAIL mul_overflow: got ok=%0b b=%0d c=%0b z=%0b expected ok=1 b=0 c=1 z=1", ok, b_reg, flag_c, flag_z); end
    endtask

    task automatic test_no_muldiv();
        bit ok;
        clear_img();
        img[0] = 8'h88; img[1] = 8'h49; img[2] = 8'hC8; img[3] = 8'hF0; img[8] = 8'd16; img[9] = 8'd3;
        prep(); start_and_wait(1'b1, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL nomul_timeout: got %0b expected 1", ok); end
        n_checks++; if ({a_reg0, b_reg0} !== {8'd16, 8'd3}) begin n_fail++; $display("FAIL nomul_regs: got %0h expected 1003", {a_reg0, b_reg0}); end
        n_checks++; if ({flag_c0, flag_z0} !== 2'b00) begin n_fail++; $display("FAIL nomul_flags: got %0b expected 00", {flag_c0, flag_z0}); end
        n_checks++; if (last_rd0[3] - last_rd0[2] !== 3) begin n_fail++; $display("FAIL nomul_cycles: got %0d expected 3", last_rd0[3] - last_rd0[2]); end
    endtask

    task automatic test_reset_mid_sta();
        bit found;
        bit idle_ok;
        clear_img();
        img[0] = 8'h88; img[1] = 8'h39; img[2] = 8'hF0; img[8] = 8'h33;
        prep();
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus1.mem_rd_en === 1'b1 && bus1.mem_addr === 4'd1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL rmid_fetch_timeout: got %0b expected 1", found); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if ({bus1.mem_wr_en, bus1.mem_rd_en, out_valid, halted, flag_z, flag_c} !== 6'b0) begin n_fail++; $display("FAIL rmid_bits: got %0b expected 0", {bus1.mem_wr_en, bus1.mem_rd_en, out_valid, halted, flag_z, flag_c}); end
        n_checks++; if ({pc, a_reg, b_reg, out_data, bus1.mem_addr, bus1.mem_wdata} !== '0) begin n_fail++; $display("FAIL rmid_regs: got %0h expected 0", {pc, a_reg, b_reg, out_data, bus1.mem_addr, bus1.mem_wdata}); end
        reset = 1'b0;
        idle_ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (bus1.mem_rd_en !== 1'b0 || halted !== 1'b0) idle_ok = 1'b0;
        end
        n_checks++; if (idle_ok !== 1'b1) begin n_fail++; $display("FAIL rmid_idle: got %0b expected 1", idle_ok); end
        n_checks++; if ({wr_cnt1, mem1[9]} !== {32'd0, 8'h00}) begin n_fail++; $display("FAIL rmid_no_write: got cnt=%0d mem=%0h expected cnt=0 mem=0", wr_cnt1, mem1[9]); end
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        n_checks++; if ({bus1.mem_rd_en, bus1.mem_addr} !== {1'b1, 4'd0}) begin n_fail++; $display("FAIL rmid_restart: got %0h expected 10", {bus1.mem_rd_en, bus1.mem_addr}); end
    endtask

    task automatic test_resume_wrap();
        bit ok;
        clear_img();
        img[0] = 8'h88; img[1] = 8'hF0; img[2] = 8'h48; img[3] = 8'hF0; img[8] = 8'd9;
        prep(); start_and_wait(1'b0, ok);
        n_checks++; if ({ok, pc, a_reg} !== {1'b1, 4'd2, 8'd9}) begin n_fail++; $display("FAIL hlt_state: got ok=%0b pc=%0d a=%0d expected ok=1 pc=2 a=9", ok, pc, a_reg); end
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        n_checks++; if ({halted, bus1.mem_rd_en, bus1.mem_addr} !== {1'b0, 1'b1, 4'd2}) begin n_fail++; $display("FAIL resume_fetch: got %0h expected 12", {halted, bus1.mem_rd_en, bus1.mem_addr}); end
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (halted === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_checks++; if ({ok, pc, b_reg} !== {1'b1, 4'd4, 8'd9}) begin n_fail++; $display("FAIL resume_run: got ok=%0b pc=%0d b=%0d expected ok=1 pc=4 b=9", ok, pc, b_reg); end

        clear_img();
        img[0] = 8'hB4; img[1] = 8'h9F; img[4] = 8'hF0; img[15] = 8'h8C; img[12] = 8'h00;
        prep(); start_and_wait(1'b0, ok);
        n_checks++; if ({ok, pc, a_reg, flag_z} !== {1'b1, 4'd5, 8'd0, 1'b1}) begin n_fail++; $display("FAIL wrap_result: got ok=%0b pc=%0d a=%0d z=%0b expected ok=1 pc=5 a=0 z=1", ok, pc, a_reg, flag_z); end
        n_checks++; if (last_rd1[0] <= last_rd1[15]) begin n_fail++; $display("FAIL wrap_fetch0: got t0=%0d t15=%0d expected t0 after t15", last_rd1[0], last_rd1[15]); end
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; run0 = 1'b0; load = 1'b0; mon_clr = 1'b1;
        clear_img();
        test_basic();
        test_reset();
        test_arith();
        test_sta_ldb();
        test_jz();
        test_muldiv();
        test_no_muldiv();
        test_reset_mid_sta();
        test_resume_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
